// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode and FSM state encodings.
package seq_alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_NEG = 3'b010,
      OP_SRL = 3'b011,
      OP_SRA = 3'b100,
      OP_SLL = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/alu_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into the MSB so the
// caller can form signed overflow on the final chunk.
module alu_chunk_adder
   import seq_alu_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = carry[CHUNK];
   assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: CHUNK-bit-per-cycle add/sub/neg and one-bit-per-cycle shifts with a
// start/busy/done handshake. Define SEQ_ALU_SAT_EN to saturate ADD/SUB on signed overflow.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             illegal
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int STEPS = WIDTH / CHUNK;

   generate
      if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_param
         $error("seq_alu: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   state_e           state;
   state_e           state_next;
   logic             load;
   logic             step;
   logic             finish;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load;

   logic [OP_W-1:0]  op_r;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry;
   logic             cmsb;

   logic [CHUNK-1:0] add_sum;
   logic             add_cout;
   logic             add_cmsb;
   logic [WIDTH-1:0] arith_next;

   logic             is_arith;
   logic             legal;
   logic             fin_ovf;
   logic             fin_cout;
   logic [WIDTH-1:0] fin_res;

   alu_chunk_adder #(.CHUNK(CHUNK)) u_adder (
      .a     (opa[CHUNK-1:0]),
      .b     (opb[CHUNK-1:0]),
      .cin   (carry),
      .sum   (add_sum),
      .cout  (add_cout),
      .c_msb (add_cmsb)
   );

   // Each sum chunk enters at the top of opa, so after STEPS steps opa holds the result.
   generate
      if (CHUNK == WIDTH) begin : g_one_chunk
         assign arith_next = add_sum;
      end else begin : g_multi_chunk
         assign arith_next = {add_sum, opa[WIDTH-1:CHUNK]};
      end
   endgenerate

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               finish     = 1'b1;
               state_next = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cnt_load = '0;
      case (op)
         OP_ADD, OP_SUB, OP_NEG: cnt_load = CNT_W'(STEPS);
         OP_SRL, OP_SRA, OP_SLL: cnt_load = CNT_W'(b[SH_W-1:0]);
         default:                cnt_load = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            cnt <= cnt_load;
         end else if (step) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // SUB and NEG become additions of an inverted operand with carry-in 1.
   always_ff @(posedge clk) begin
      if (load) begin
         op_r  <= op;
         opa   <= a;
         opb   <= b;
         carry <= 1'b0;
         cmsb  <= 1'b0;
         case (op)
            OP_SUB: begin
               opb   <= ~b;
               carry <= 1'b1;
            end
            OP_NEG: begin
               opa   <= '0;
               opb   <= ~a;
               carry <= 1'b1;
            end
            default: ;
         endcase
      end else if (step) begin
         case (op_r)
            OP_ADD, OP_SUB, OP_NEG: begin
               opa   <= arith_next;
               opb   <= opb >> CHUNK;
               carry <= add_cout;
               cmsb  <= add_cmsb;
            end
            OP_SRL: begin
               opa   <= {1'b0, opa[WIDTH-1:1]};
               carry <= opa[0];
            end
            OP_SRA: begin
               opa   <= {opa[WIDTH-1], opa[WIDTH-1:1]};
               carry <= opa[0];
            end
            OP_SLL: begin
               opa   <= {opa[WIDTH-2:0], 1'b0};
               carry <= opa[WIDTH-1];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      is_arith = (op_r == OP_ADD) || (op_r == OP_SUB) || (op_r == OP_NEG);
      legal    = is_arith || (op_r == OP_SRL) || (op_r == OP_SRA) || (op_r == OP_SLL);
      fin_ovf  = is_arith & (carry ^ cmsb);
      fin_cout = legal & carry;
      fin_res  = legal ? opa : '0;
`ifdef SEQ_ALU_SAT_EN
      if (fin_ovf && ((op_r == OP_ADD) || (op_r == OP_SUB))) begin
         fin_res = {~opa[WIDTH-1], {(WIDTH-1){opa[WIDTH-1]}}};
      end
`else
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else if (finish) begin
         result  <= fin_res;
         cout    <= fin_cout;
         ovf     <= fin_ovf;
         zero    <= (fin_res == '0);
         illegal <= ~legal;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8, CHUNK=4): directed vectors push expectations,
// a negedge monitor pops and compares whenever done is high.
module tb_seq_alu;
   import seq_alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       cout;
   logic       ovf;
   logic       zero;
   logic       illegal;

   seq_alu #(.WIDTH(8), .CHUNK(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .cout    (cout),
      .ovf     (ovf),
      .zero    (zero),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

`ifdef SEQ_ALU_SAT_EN
   localparam logic [7:0] ADD_OVF_RES = 8'h7F;
   localparam logic [7:0] SUB_OVF_RES = 8'h80;
`else
   localparam logic [7:0] ADD_OVF_RES = 8'h80;
   localparam logic [7:0] SUB_OVF_RES = 8'h7F;
`endif

   typedef struct {
      string      name;
      logic [7:0] res;
      logic       co;
      logic       ov;
      logic       ill;
      int         lat;
      int         t0;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk({mon_e.name, ".result"},  32'(result),  32'(mon_e.res));
            chk({mon_e.name, ".cout"},    32'(cout),    32'(mon_e.co));
            chk({mon_e.name, ".ovf"},     32'(ovf),     32'(mon_e.ov));
            chk({mon_e.name, ".zero"},    32'(zero),    32'(mon_e.res == 8'h00));
            chk({mon_e.name, ".illegal"}, 32'(illegal), 32'(mon_e.ill));
            chk({mon_e.name, ".latency"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] res, input logic co,
                        input logic ov, input logic ill, input int lat,
                        input bit b2b, input bit push);
      exp_t e;
      if (!b2b) @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.name = name;
         e.res  = res;
         e.co   = co;
         e.ov   = ov;
         e.ill  = ill;
         e.lat  = lat;
         e.t0   = cyc;
         sbq.push_back(e);
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s.timeout: got done=0 after 40 cycles, expected done=1", name);
      end
   endtask

   task automatic run(input string name, input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] res, input logic co,
                      input logic ov, input logic ill, input int lat);
      issue(name, o, x, y, res, co, ov, ill, lat, 1'b0, 1'b1);
      wait_done(name);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset.busy",    32'(busy),    32'd0);
      chk("reset.done",    32'(done),    32'd0);
      chk("reset.result",  32'(result),  32'd0);
      chk("reset.cout",    32'(cout),    32'd0);
      chk("reset.ovf",     32'(ovf),     32'd0);
      chk("reset.zero",    32'(zero),    32'd0);
      chk("reset.illegal", 32'(illegal), 32'd0);
      rst_n = 1'b1;

      //   name         op      a      b      result       co    ov    ill   lat
      run("add_7f_01",  OP_ADD, 8'h7F, 8'h01, ADD_OVF_RES, 1'b0, 1'b1, 1'b0, 3);
      run("add_ff_01",  OP_ADD, 8'hFF, 8'h01, 8'h00,       1'b1, 1'b0, 1'b0, 3);
      run("sub_05_07",  OP_SUB, 8'h05, 8'h07, 8'hFE,       1'b0, 1'b0, 1'b0, 3);
      run("sub_07_07",  OP_SUB, 8'h07, 8'h07, 8'h00,       1'b1, 1'b0, 1'b0, 3);
      run("sub_80_01",  OP_SUB, 8'h80, 8'h01, SUB_OVF_RES, 1'b1, 1'b1, 1'b0, 3);
      run("neg_80",     OP_NEG, 8'h80, 8'h00, 8'h80,       1'b0, 1'b1, 1'b0, 3);
      run("neg_01",     OP_NEG, 8'h01, 8'h00, 8'hFF,       1'b0, 1'b0, 1'b0, 3);
      run("neg_00",     OP_NEG, 8'h00, 8'h00, 8'h00,       1'b1, 1'b0, 1'b0, 3);
      run("sra_90_3",   OP_SRA, 8'h90, 8'h03, 8'hF2,       1'b0, 1'b0, 1'b0, 4);
      run("sra_80_7",   OP_SRA, 8'h80, 8'h07, 8'hFF,       1'b0, 1'b0, 1'b0, 8);
      run("sll_81_1",   OP_SLL, 8'h81, 8'h01, 8'h02,       1'b1, 1'b0, 1'b0, 2);
      run("sll_01_7",   OP_SLL, 8'h01, 8'h07, 8'h80,       1'b0, 1'b0, 1'b0, 8);
      run("srl_a5_0",   OP_SRL, 8'hA5, 8'h00, 8'hA5,       1'b0, 1'b0, 1'b0, 1);
      run("srl_a5_b3",  OP_SRL, 8'hA5, 8'h0B, 8'h14,       1'b1, 1'b0, 1'b0, 4);
      run("illegal_6",  3'b110, 8'h12, 8'h34, 8'h00,       1'b0, 1'b0, 1'b1, 1);
      run("illegal_7",  3'b111, 8'h56, 8'h78, 8'h00,       1'b0, 1'b0, 1'b1, 1);

      // Back-to-back: start held in the DONE cycle launches the next operation.
      run("b2b_first",  OP_ADD, 8'h10, 8'h22, 8'h32, 1'b0, 1'b0, 1'b0, 3);
      issue("b2b_second", OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1);
      wait_done("b2b_second");

      // start while busy must be ignored.
      issue("busy_add", OP_ADD, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1);
      @(negedge clk);
      chk("busy_add.busy", 32'(busy), 32'd1);
      op    = OP_SUB;
      a     = 8'h10;
      b     = 8'h20;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_add");

      // Reset during RUN: outputs clear at once and the SUB never completes.
      issue("rst_sub", OP_SUB, 8'h09, 8'h02, 8'h07, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("midrst.busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst.busy",    32'(busy),    32'd0);
      chk("midrst.done",    32'(done),    32'd0);
      chk("midrst.result",  32'(result),  32'd0);
      chk("midrst.cout",    32'(cout),    32'd0);
      chk("midrst.ovf",     32'(ovf),     32'd0);
      chk("midrst.zero",    32'(zero),    32'd0);
      chk("midrst.illegal", 32'(illegal), 32'd0);
      repeat (2) @(negedge clk);
      chk("midrst.done_held", 32'(done), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst.idle_busy", 32'(busy), 32'd0);
      run("post_rst_add", OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 3);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
